dm_responder: RTL and testbench
===============================

# dm_responder

Multi-cycle data-memory responder answering the pipeline's MEM-stage load/store requests over a valid/ready request channel and a one-cycle response pulse. It holds a word-addressed RAM and returns read data or a write acknowledge a fixed, parameterised number of cycles after acceptance. While it is busy, `req_ready_o` is low and the pipeline's hazard logic stalls on it.

## Interface
- `DEPTH`, default 256: number of 32-bit words; power of two, at least 2.
- `LATENCY`, default 3: cycles from the accept edge to the `resp_valid_o` rise; 1 to 15.
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: the request fields are valid.
- `req_ready_o` output 1: the responder can accept a request.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_addr_i` input 32: byte address.
- `req_wdata_i` input 32: store data.
- `resp_valid_o` output 1: one-cycle response pulse.
- `resp_rdata_o` output 32: load data; 0 for stores and errors.
- `resp_err_o` output 1: the request was misaligned or out of range; valid with `resp_valid_o`.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready_o` = 1.
  - Accept happens on a rising edge with `req_valid_i` && `req_ready_o`.
  - At accept, latch we, addr and wdata; load the counter with LATENCY-1; go to WAIT.
- **WAIT**
  - `req_ready_o` = 0.
  - At each edge: if the counter is 0, perform the access and go to RESP; otherwise decrement the counter.
  - Request inputs are ignored; the latched copies are used.
- **Access, at the WAIT→RESP edge**
  - Word index is addr[log2(DEPTH)+1:2].
  - Error if addr[1:0] != 0, or any addr bit above the index field is nonzero.
  - Error: no array access; `resp_rdata_o` <= 0; `resp_err_o` <= 1.
  - Store: mem[index] <= wdata; `resp_rdata_o` <= 0; `resp_err_o` <= 0.
  - Load: `resp_rdata_o` <= mem[index]; `resp_err_o` <= 0.
- **RESP**
  - `resp_valid_o` = 1 for exactly one cycle; `req_ready_o` = 0.
  - The next edge returns to IDLE unconditionally. There is no response backpressure.
- **Response holding**
  - `resp_rdata_o` and `resp_err_o` hold their values until the next access edge.
  - Consumers sample them only while `resp_valid_o` = 1.
- **Reset behaviour**
  - The RAM array is not reset; its contents are unknown until written.
  - Reset in WAIT aborts the request; a store not yet committed is discarded.
  - A store already committed, i.e. reset during RESP, stays in memory.
- A request held on `req_valid_i` while `req_ready_o` = 0 is not accepted. The requester keeps it stable until it sees ready.

## Timing
- **Reset values:** state IDLE, `req_ready_o` = 1, `resp_valid_o` = 0, `resp_rdata_o` = 0, `resp_err_o` = 0, counter 0.
- **Latency:** accept at edge E0 → `resp_valid_o` high from edge E(LATENCY) to E(LATENCY+1).
  - LATENCY = 1: the response follows in the cycle right after the accept edge.
- **Ready:** `req_ready_o` rises at E(LATENCY+1). The earliest next accept is at E(LATENCY+2).
- **Throughput:** one request per LATENCY+2 cycles.
- **Output registration:** all outputs are registered or decoded from state only. There is no combinational path from any `req_*` input to any output.
- **Counter:** 4 bits; it never wraps below 0.

## Test plan
- **Reset values:** with `rst_i` held low for 3 cycles, every output matches the reset values above. Then release `rst_i` and confirm `req_ready_o` = 1.
- **Store then load:** store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010.
  - The store response comes at E3 with rdata 0 and err 0.
  - The load response comes 3 cycles after its accept with rdata 0xDEADBEEF and err 0.
- **Back-to-back:** hold `req_valid_i` high with a stream of 4 loads.
  - Accepts are spaced exactly LATENCY+2 = 5 cycles apart.
  - `req_ready_o` is low for 4 cycles after each accept.
- **Errors:** issue one load and one store, each error case causing no memory change.
  - Load 0x0000_0012 → err 1, rdata 0.
  - Store 0x0000_0400 with DEPTH = 256 → err 1.
  - A follow-up load of 0x0000_0000 returns its prior value.
- **Reset mid-WAIT:** store 0x12345678 to 0x4, then pulse `rst_i` low at E1. A later load of 0x4 returns the earlier value, and no `resp_valid_o` occurs for the aborted store.
- **LATENCY = 1 build:** a load accepted at E0 has `resp_valid_o` high between E1 and E2, and `req_ready_o` returns high at E2.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle word-addressed data memory answering MEM-stage
// load/store requests with a fixed-latency, one-cycle response pulse.
module dm_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = 4;
    localparam int unsigned LSB = AW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [DW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            ready_q;
    logic            valid_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;

    logic [DW-1:0]   mem [DEPTH];

    logic [AW-1:0]   idx_c;
    logic            err_c;
    logic            access_c;

    // Decode of the latched request: word index, range/alignment error, access edge
    assign idx_c    = addr_q[AW+1:2];
    assign err_c    = (addr_q[1:0] != 2'b00) || ((addr_q >> LSB) != '0);
    assign access_c = (state_q == WAIT) && (cnt_q == '0);

    // RAM write port; array is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (access_c && we_q && !err_c) begin
            mem[idx_c] <= wdata_q;
        end
    end

    // Request FSM with registered handshake and response outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && ready_q) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        cnt_q   <= CW'(LATENCY - 1);
                        ready_q <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        if (err_c) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end else if (we_q) begin
                            rdata_q <= '0;
                            err_q   <= 1'b0;
                        end else begin
                            rdata_q <= mem[idx_c];
                            err_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (LATENCY=3 and LATENCY=1 builds).
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        rst1;
    logic        req_valid1, req_ready1, req_we1;
    logic [31:0] req_addr1, req_wdata1;
    logic        resp_valid1, resp_err1;
    logic [31:0] resp_rdata1;

    int checks = 0;
    int errors = 0;

    dm_responder #(.DEPTH(256), .LATENCY(3)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err)
    );

    dm_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk_i        (clk),
        .rst_i        (rst1),
        .req_valid_i  (req_valid1),
        .req_ready_o  (req_ready1),
        .req_we_i     (req_we1),
        .req_addr_i   (req_addr1),
        .req_wdata_i  (req_wdata1),
        .resp_valid_o (resp_valid1),
        .resp_rdata_o (resp_rdata1),
        .resp_err_o   (resp_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the LATENCY=3 instance, checking latency and response
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err);
        int n;
        chk({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        chk({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
        n = 0;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        tick();
        chk({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    // One transaction on the LATENCY=1 instance
    task automatic txn1(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
        req_valid1 = 1'b1; req_we1 = we; req_addr1 = addr; req_wdata1 = wdata;
        tick();
        req_valid1 = 1'b0;
        chk({tag, "_e0_valid"}, 32'(resp_valid1), 32'd0);
        chk({tag, "_e0_ready"}, 32'(req_ready1), 32'd0);
        tick();
        chk({tag, "_e1_valid"}, 32'(resp_valid1), 32'd1);
        chk({tag, "_e1_ready"}, 32'(req_ready1), 32'd0);
        chk({tag, "_e1_rdata"}, resp_rdata1, exp_rdata);
        chk({tag, "_e1_err"}, 32'(resp_err1), 32'd0);
        tick();
        chk({tag, "_e2_valid"}, 32'(resp_valid1), 32'd0);
        chk({tag, "_e2_ready"}, 32'(req_ready1), 32'd1);
    endtask

    initial begin
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        int k, r, last_acc, low, seen;
        logic rdy_before;

        rst = 1'b0; rst1 = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst1_ready", 32'(req_ready1), 32'd1);
        chk("rst1_valid", 32'(resp_valid1), 32'd0);
        rst = 1'b1; rst1 = 1'b1;
        tick();
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Store then load
        txn("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
        txn("ld10", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // Preload for the stream and error tests
        txn("st00", 1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'd0, 1'b0);
        txn("st04", 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'd0, 1'b0);
        txn("st08", 1'b1, 32'h0000_0008, 32'h1111_2222, 32'd0, 1'b0);

        // Back-to-back loads with valid held high
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'h10;
        exps[0] = 32'hA5A5_0000; exps[1] = 32'h0BAD_F00D;
        exps[2] = 32'h1111_2222; exps[3] = 32'hDEAD_BEEF;
        k = 0; r = 0; last_acc = -1; low = 0;
        req_we = 1'b0; req_addr = addrs[0]; req_valid = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            rdy_before = req_ready;
            tick();
            if (rdy_before && req_valid) begin
                if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd5);
                last_acc = cyc;
                k++;
                if (k < 4) req_addr = addrs[k];
                else req_valid = 1'b0;
            end
            if (resp_valid) begin
                if (r < 4) chk("b2b_rdata", resp_rdata, exps[r]);
                r++;
            end
            if (!req_ready) low++;
            else if (low > 0) begin
                chk("b2b_ready_low", 32'(low), 32'd4);
                low = 0;
            end
        end
        chk("b2b_accepts", 32'(k), 32'd4);
        chk("b2b_resps", 32'(r), 32'd4);

        // Error cases leave memory untouched
        txn("ld_misal", 1'b0, 32'h0000_0012, 32'd0, 32'd0, 1'b1);
        txn("st_oor", 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'd0, 1'b1);
        txn("ld00_after_err", 1'b0, 32'h0000_0000, 32'd0, 32'hA5A5_0000, 1'b0);

        // Reset during WAIT aborts the store
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h1234_5678;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        chk("midrst_no_resp", 32'(seen), 32'd0);
        txn("ld04_after_abort", 1'b0, 32'h0000_0004, 32'd0, 32'h0BAD_F00D, 1'b0);

        // LATENCY=1 build
        txn1("l1_st", 1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'd0);
        txn1("l1_ld", 1'b0, 32'h0000_0020, 32'd0, 32'hCAFE_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
